hilo_div_seq: RTL and testbench
===============================

// Module: hilo_div_seq
// PURPOSE
//  Multi-cycle restoring divider that computes the quotient (lo) and remainder (hi)
//  for the single-cycle core's div instruction, replacing the combinational divide.
//  Inputs come from the regfile read ports (rs/rt); outputs feed the hi/lo special
//  register write port, which is enabled for one cycle by done.
//  stall freezes the pc and regfile writes while the operation is in flight.
// PARAMETERS
//  WIDTH   32  operand/result width in bits; iteration count = WIDTH
//  SIGNED  0   0: unsigned divide (divu); 1: signed divide (div, truncate toward zero)
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      asynchronous, active-high reset
//  start      in   1      request a divide; sampled only in IDLE or DONE
//  dividend   in   WIDTH  rs operand, captured on the accepting edge
//  divisor    in   WIDTH  rt operand, captured on the accepting edge
//  stall      out  1      hold pc/regfile: combinational (start & ~busy) | busy
//  busy       out  1      high while state == RUN
//  done       out  1      one-cycle pulse; quotient/remainder valid; hi/lo write enable
//  div_zero   out  1      registered; set with done when divisor was 0; held until next accept
//  quotient   out  WIDTH  registered; to lo; held stable until next done
//  remainder  out  WIDTH  registered; to hi; held stable until next done
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; busy, done, div_zero = 0; quotient, remainder = 0;
//   counter cleared. An in-flight operation is abandoned with no done pulse.
//  FSM: IDLE --start--> RUN (or DONE directly if divisor==0); RUN --count==0--> DONE;
//   DONE --start--> RUN/DONE (back-to-back accept); DONE --~start--> IDLE.
//  Accept edge: latch |dividend|, |divisor| (abs only if SIGNED=1), sign flags,
//   partial remainder R=0, shift register Q=dividend magnitude, counter=WIDTH.
//  RUN, per cycle: {R,Q} <<= 1; if R >= D then R -= D and Q[0] = 1; counter -= 1.
//   R is WIDTH+1 bits internally, so there is no overflow at any divisor value.
//  Latency: start accepted at edge 0 -> RUN for edges 1..WIDTH -> done high for the
//   cycle after edge WIDTH (i.e. WIDTH+1 cycles from accept to the done cycle).
//  On the edge that leaves RUN, quotient/remainder are loaded; SIGNED=1 correction:
//   quotient negated if operand signs differ; remainder takes the dividend's sign.
//   Signed overflow (-2^(WIDTH-1) / -1): quotient = -2^(WIDTH-1), remainder = 0 (wraps).
//  Divide by zero: no iterations; DONE on the next edge; quotient = all ones,
//   remainder = dividend (unmodified, signed or not); div_zero = 1.
//  start while RUN: ignored (no restart, no error); stall stays high from busy.
//  done and stall: stall is low in the done cycle unless start is high, so the core
//   advances and hi/lo captures the results on the same edge.
//  Operands are sampled only on the accepting edge; later changes have no effect.
// TESTING
//  Unsigned 100/7: start 1 cycle -> busy for 32 cycles, done at cycle 33, quotient=14,
//   remainder=2, div_zero=0.
//  Divide by zero 0x1234/0: done on the next cycle, quotient=0xFFFFFFFF, remainder=0x1234,
//   div_zero=1, busy never asserted.
//  SIGNED=1, -7/2: quotient=0xFFFFFFFD (-3), remainder=0xFFFFFFFF (-1); and
//   0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0.
//  start pulsed again at cycle 10 of RUN with new operands -> ignored; the original
//   result appears at cycle 33; exactly one done pulse.
//  Reset asserted at cycle 15 of RUN -> all outputs 0 immediately (async), no done pulse;
//   a new start after release gives a correct result with full latency.
//  Back-to-back: start held high in the done cycle with 0xFFFFFFFF/0x10 -> re-enters RUN;
//   the second done 33 cycles later gives quotient=0x0FFFFFFF, remainder=0xF; the first
//   result is held until then.

Source files
------------

// File: rtl/hilo_div_seq.sv
// hilo_div_seq: multi-cycle restoring divider for div/divu.
// quotient feeds lo, remainder feeds hi; done is the hi/lo write enable.
module hilo_div_seq #(
  parameter int WIDTH  = 32,
  parameter bit SIGNED = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_nxt;

  logic [WIDTH:0]     r_reg, r_sh, r_nxt;
  logic [WIDTH-1:0]   q_reg, q_nxt, d_reg;
  logic [2*WIDTH:0]   rq_sh;
  logic [CW-1:0]      cnt;
  logic               neg_q, neg_r;
  logic               accept, div0, last, ge;
  logic               sgn_a, sgn_b;
  logic [WIDTH-1:0]   a_mag, b_mag, rem_mag;

  assign busy  = (state == RUN);
  assign done  = (state == DONE);
  assign stall = (start & ~busy) | busy;

  assign accept = start && (state != RUN);
  assign div0   = (divisor == '0);
  assign last   = (cnt == CW'(1));

  assign sgn_a = SIGNED && dividend[WIDTH-1];
  assign sgn_b = SIGNED && divisor[WIDTH-1];
  assign a_mag = sgn_a ? -dividend : dividend;
  assign b_mag = sgn_b ? -divisor : divisor;

  // One restoring step: R gets an extra top bit so R >= D never overflows.
  assign rq_sh   = {r_reg, q_reg} << 1;
  assign r_sh    = rq_sh[2*WIDTH:WIDTH];
  assign ge      = (r_sh >= {1'b0, d_reg});
  assign r_nxt   = ge ? (r_sh - {1'b0, d_reg}) : r_sh;
  assign q_nxt   = rq_sh[WIDTH-1:0] | WIDTH'(ge);
  assign rem_mag = r_nxt[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: if (start) state_nxt = div0 ? DONE : RUN;
      RUN:  if (last)  state_nxt = DONE;
      DONE: begin
        if (start) state_nxt = div0 ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_reg     <= '0;
      q_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      neg_q     <= 1'b0;
      neg_r     <= 1'b0;
      div_zero  <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
    end else if (accept) begin
      div_zero <= div0;
      if (div0) begin
        quotient  <= '1;
        remainder <= dividend;
      end else begin
        r_reg <= '0;
        q_reg <= a_mag;
        d_reg <= b_mag;
        cnt   <= CW'(WIDTH);
        neg_q <= sgn_a ^ sgn_b;
        neg_r <= sgn_a;
      end
    end else if (state == RUN) begin
      r_reg <= r_nxt;
      q_reg <= q_nxt;
      cnt   <= cnt - CW'(1);
      if (last) begin
        quotient  <= neg_q ? -q_nxt : q_nxt;
        remainder <= neg_r ? -rem_mag : rem_mag;
      end
    end
  end

endmodule

// File: tb/tb_hilo_div_seq.sv
// Bench for hilo_div_seq: unsigned and signed instances,
// scoreboard queues filled on accept and drained on done.
module tb_hilo_div_seq;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         u_start, u_stall, u_busy, u_done, u_dz;
  logic [W-1:0] u_a, u_b, u_q, u_r;
  logic         s_start, s_stall, s_busy, s_done, s_dz;
  logic [W-1:0] s_a, s_b, s_q, s_r;

  hilo_div_seq #(.WIDTH(W), .SIGNED(1'b0)) u_dut (
    .clk(clk), .reset(reset), .start(u_start),
    .dividend(u_a), .divisor(u_b),
    .stall(u_stall), .busy(u_busy), .done(u_done),
    .div_zero(u_dz), .quotient(u_q), .remainder(u_r)
  );

  hilo_div_seq #(.WIDTH(W), .SIGNED(1'b1)) s_dut (
    .clk(clk), .reset(reset), .start(s_start),
    .dividend(s_a), .divisor(s_b),
    .stall(s_stall), .busy(s_busy), .done(s_done),
    .div_zero(s_dz), .quotient(s_q), .remainder(s_r)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
  } exp_t;

  exp_t u_sb[$];
  exp_t s_sb[$];
  int checks = 0;
  int failures = 0;

  function automatic exp_t model(bit sgn, logic [W-1:0] a, logic [W-1:0] b);
    exp_t e;
    e.dz = (b == '0);
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else if (!sgn) begin
      e.q = a / b;
      e.r = a % b;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      e.q = a;
      e.r = '0;
    end else begin
      e.q = $signed(a) / $signed(b);
      e.r = $signed(a) % $signed(b);
    end
    return e;
  endfunction

  // Call just after a negedge; the next posedge is the accept edge.
  task automatic issue(bit sgn, logic [W-1:0] a, logic [W-1:0] b);
    if (sgn) begin
      s_a = a; s_b = b; s_start = 1'b1;
      s_sb.push_back(model(1'b1, a, b));
    end else begin
      u_a = a; u_b = b; u_start = 1'b1;
      u_sb.push_back(model(1'b0, a, b));
    end
  endtask

  task automatic wait_done(bit sgn, output int lat, output int nbusy,
                           output exp_t got, output bit ok);
    lat = 0; nbusy = 0; ok = 1'b0; got = '0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (i == 1) begin
        if (sgn) s_start = 1'b0;
        else     u_start = 1'b0;
      end
      #1;
      if (sgn ? s_busy : u_busy) nbusy++;
      if (sgn ? s_done : u_done) begin
        lat = i;
        got = sgn ? {s_q, s_r, s_dz} : {u_q, u_r, u_dz};
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    u_start = 1'b0; u_a = '0; u_b = '0;
    s_start = 1'b0; s_a = '0; s_b = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({u_busy, u_done, u_dz, u_stall, u_q, u_r} !== '0) begin
      failures++;
      $display("FAIL reset_u got b%b d%b z%b s%b q%h r%h want all 0",
               u_busy, u_done, u_dz, u_stall, u_q, u_r);
    end
    checks++;
    if ({s_busy, s_done, s_dz, s_stall, s_q, s_r} !== '0) begin
      failures++;
      $display("FAIL reset_s got b%b d%b z%b s%b q%h r%h want all 0",
               s_busy, s_done, s_dz, s_stall, s_q, s_r);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_unsigned;
    logic [W-1:0] ta[6] = '{32'd100, 32'hFFFF_FFFF, 32'd5,
                            32'hDEAD_BEEF, 32'hFFFF_FFFF, 32'd0};
    logic [W-1:0] tb[6] = '{32'd7, 32'd1, 32'd10,
                            32'h1234, 32'hFFFF_FFFF, 32'd9};
    logic [W-1:0] a, b;
    int lat, nb;
    exp_t got, e;
    bit ok;
    for (int i = 0; i < 9; i++) begin
      if (i < 6) begin
        a = ta[i]; b = tb[i];
      end else begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 31);
        if (b == '0) b = 32'd3;
      end
      issue(1'b0, a, b);
      #1;
      checks++;
      if (u_stall !== 1'b1) begin
        failures++;
        $display("FAIL u_stall_start got %b want 1", u_stall);
      end
      wait_done(1'b0, lat, nb, got, ok);
      e = u_sb.pop_front();
      checks++;
      if (!ok || lat != 33 || nb != 32) begin
        failures++;
        $display("FAIL u_latency %h/%h got done@%0d busy=%0d want done@33 busy=32",
                 a, b, lat, nb);
      end
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL u_result %h/%h got q%h r%h z%b want q%h r%h z%b",
                 a, b, got.q, got.r, got.dz, e.q, e.r, e.dz);
      end
      checks++;
      if (u_stall !== 1'b0) begin
        failures++;
        $display("FAIL u_stall_done got %b want 0", u_stall);
      end
      @(negedge clk);
      #1;
      checks++;
      if (u_done !== 1'b0 || u_q !== e.q) begin
        failures++;
        $display("FAIL u_pulse got done=%b q%h want done=0 q%h", u_done, u_q, e.q);
      end
    end
  endtask

  task automatic test_div_zero;
    int lat, nb;
    exp_t got, e;
    bit ok;
    issue(1'b0, 32'h1234, 32'h0);
    wait_done(1'b0, lat, nb, got, ok);
    e = u_sb.pop_front();
    checks++;
    if (!ok || lat != 1 || nb != 0 || got !== e) begin
      failures++;
      $display("FAIL u_div0 got done@%0d busy=%0d q%h r%h z%b want done@1 busy=0 q%h r%h z%b",
               lat, nb, got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (u_dz !== 1'b1 || u_q !== '1 || u_r !== 32'h1234) begin
      failures++;
      $display("FAIL u_div0_hold got z%b q%h r%h want z1 q%h r%h",
               u_dz, u_q, u_r, 32'hFFFF_FFFF, 32'h1234);
    end
    issue(1'b1, 32'h8000_0000, 32'h0);
    wait_done(1'b1, lat, nb, got, ok);
    e = s_sb.pop_front();
    checks++;
    if (!ok || lat != 1 || nb != 0 || got !== e) begin
      failures++;
      $display("FAIL s_div0 got done@%0d busy=%0d q%h r%h z%b want done@1 busy=0 q%h r%h z%b",
               lat, nb, got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
    @(negedge clk);
  endtask

  task automatic test_signed;
    logic [W-1:0] ta[7] = '{-32'sd7, 32'h8000_0000, 32'd7, -32'sd7,
                            -32'sd100, 32'h7FFF_FFFF, 32'h8000_0000};
    logic [W-1:0] tb[7] = '{32'd2, 32'hFFFF_FFFF, -32'sd2, -32'sd2,
                            32'd7, 32'hFFFF_FFFF, 32'd1};
    logic [W-1:0] a, b;
    int lat, nb;
    exp_t got, e;
    bit ok;
    for (int i = 0; i < 10; i++) begin
      if (i < 7) begin
        a = ta[i]; b = tb[i];
      end else begin
        a = $urandom;
        b = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 1) == 1) b = -b;
        if (b == '0) b = -32'sd5;
      end
      issue(1'b1, a, b);
      wait_done(1'b1, lat, nb, got, ok);
      e = s_sb.pop_front();
      checks++;
      if (!ok || lat != 33 || nb != 32) begin
        failures++;
        $display("FAIL s_latency %h/%h got done@%0d busy=%0d want done@33 busy=32",
                 a, b, lat, nb);
      end
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL s_result %h/%h got q%h r%h z%b want q%h r%h z%b",
                 a, b, got.q, got.r, got.dz, e.q, e.r, e.dz);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignore_start;
    int ndone, at;
    exp_t got, e;
    ndone = 0; at = 0; got = '0;
    issue(1'b0, 32'd1000, 32'd3);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      if (i == 1) u_start = 1'b0;
      if (i == 10) begin
        u_a = 32'd5; u_b = 32'd1; u_start = 1'b1;
      end
      if (i == 11) u_start = 1'b0;
      #1;
      if (i == 10) begin
        checks++;
        if (u_stall !== 1'b1 || u_busy !== 1'b1) begin
          failures++;
          $display("FAIL ign_stall got stall=%b busy=%b want 1 1", u_stall, u_busy);
        end
      end
      if (u_done) begin
        ndone++;
        if (at == 0) begin
          at = i;
          got = {u_q, u_r, u_dz};
        end
      end
    end
    e = u_sb.pop_front();
    checks++;
    if (ndone != 1 || at != 33) begin
      failures++;
      $display("FAIL ign_pulses got %0d done at %0d want 1 done at 33", ndone, at);
    end
    checks++;
    if (got !== e) begin
      failures++;
      $display("FAIL ign_result got q%h r%h z%b want q%h r%h z%b",
               got.q, got.r, got.dz, e.q, e.r, e.dz);
    end
  endtask

  task automatic test_back_to_back;
    int lat, nb;
    exp_t got, e1, e2;
    bit ok;
    issue(1'b0, 32'h1234_5678, 32'h100);
    wait_done(1'b0, lat, nb, got, ok);
    e1 = u_sb.pop_front();
    checks++;
    if (!ok || got !== e1) begin
      failures++;
      $display("FAIL b2b_first got q%h r%h want q%h r%h", got.q, got.r, e1.q, e1.r);
    end
    issue(1'b0, 32'hFFFF_FFFF, 32'h10);
    #1;
    checks++;
    if (u_stall !== 1'b1) begin
      failures++;
      $display("FAIL b2b_stall got %b want 1", u_stall);
    end
    @(negedge clk);
    u_start = 1'b0;
    #1;
    checks++;
    if (u_busy !== 1'b1 || u_q !== e1.q || u_r !== e1.r) begin
      failures++;
      $display("FAIL b2b_hold got busy=%b q%h r%h want busy=1 q%h r%h",
               u_busy, u_q, u_r, e1.q, e1.r);
    end
    // One RUN cycle was already consumed above.
    wait_done(1'b0, lat, nb, got, ok);
    e2 = u_sb.pop_front();
    checks++;
    if (!ok || lat != 32 || nb != 31) begin
      failures++;
      $display("FAIL b2b_latency got done@%0d busy=%0d want done@32 busy=31", lat, nb);
    end
    checks++;
    if (got !== e2 || got.q !== 32'h0FFF_FFFF || got.r !== 32'hF) begin
      failures++;
      $display("FAIL b2b_second got q%h r%h z%b want q%h r%h z0",
               got.q, got.r, got.dz, 32'h0FFF_FFFF, 32'hF);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midrun;
    int lat, nb, ndone;
    exp_t got, e;
    bit ok;
    issue(1'b0, 32'hDEAD_BEEF, 32'd3);
    for (int i = 1; i <= 15; i++) begin
      @(negedge clk);
      if (i == 1) u_start = 1'b0;
    end
    #2 reset = 1'b1;
    #1;
    u_sb.delete();
    checks++;
    if ({u_busy, u_done, u_dz, u_stall, u_q, u_r} !== '0) begin
      failures++;
      $display("FAIL async_reset got b%b d%b z%b s%b q%h r%h want all 0",
               u_busy, u_done, u_dz, u_stall, u_q, u_r);
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      #1;
      if (u_done || u_busy) ndone++;
    end
    checks++;
    if (ndone != 0) begin
      failures++;
      $display("FAIL abandon got %0d active cycles want 0", ndone);
    end
    issue(1'b0, 32'd100, 32'd7);
    wait_done(1'b0, lat, nb, got, ok);
    e = u_sb.pop_front();
    checks++;
    if (!ok || lat != 33 || got !== e || got.q !== 32'd14 || got.r !== 32'd2) begin
      failures++;
      $display("FAIL after_reset got done@%0d q%h r%h want done@33 q%h r%h",
               lat, got.q, got.r, 32'd14, 32'd2);
    end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_div_zero();
    test_signed();
    test_ignore_start();
    test_back_to_back();
    test_reset_midrun();
    checks++;
    if (u_sb.size() != 0 || s_sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_left got %0d/%0d want 0/0", u_sb.size(), s_sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
